// File: rtl/fetch_align.sv
// RV32IC fetch/realign: drives imem word addresses and turns the returned words into 16/32-bit instructions.
// Latency: request on the first edge, instruction two cycles later; stall holds the head and fetching stops once the queue is full.
module fetch_align #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_c
);

  // Byte PCs live in the imem address space and wrap with it.
  localparam logic [31:0] PC_MASK = 32'((64'h1 << (ADDR_WIDTH + 2)) - 64'h1);

  logic [15:0] q [4];
  logic [2:0]  hcnt;
  logic [31:0] head_pc;
  logic [31:0] fetch_pc;
  logic        rsp_valid;
  logic        drop_lo;

  logic        q0_is_c;
  logic        consume;
  logic [1:0]  popped;
  logic [2:0]  hrem;
  logic        issue;
  logic [15:0] sh   [4];
  logic [15:0] in_h [2];
  logic [1:0]  in_n;
  logic [15:0] q_n  [4];
  logic [2:0]  hcnt_n;

  assign q0_is_c     = (q[0][1:0] != 2'b11);
  assign instr_valid = ((hcnt >= 3'd1) && q0_is_c) || (hcnt >= 3'd2);
  assign instr       = q0_is_c ? {16'h0, q[0]} : {q[1], q[0]};
  assign instr_is_c  = instr_valid && q0_is_c;
  assign instr_pc    = head_pc;
  assign imem_addr   = fetch_pc[ADDR_WIDTH+1:2];

  assign consume = instr_valid && !stall && !redirect_valid;

  always_comb begin
    popped = 2'd0;
    if (consume) popped = q0_is_c ? 2'd1 : 2'd2;
    hrem = hcnt - {1'b0, popped};
    // Only request when the queue can absorb both the in-flight word and this one.
    issue = !redirect_valid && ((hrem + (rsp_valid ? 3'd2 : 3'd0)) <= 3'd2);
  end

  always_comb begin
    sh[0] = (popped == 2'd2) ? q[2] : (popped == 2'd1) ? q[1] : q[0];
    sh[1] = (popped == 2'd2) ? q[3] : (popped == 2'd1) ? q[2] : q[1];
    sh[2] = (popped == 2'd1) ? q[3] : q[2];
    sh[3] = q[3];
    in_h[0] = drop_lo ? imem_dout[31:16] : imem_dout[15:0];
    in_h[1] = imem_dout[31:16];
    in_n    = rsp_valid ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
    for (int i = 0; i < 4; i++) begin
      q_n[i] = sh[i];
      if ((3'(i) >= hrem) && ((3'(i) - hrem) < {1'b0, in_n}))
        q_n[i] = (3'(i) == hrem) ? in_h[0] : in_h[1];
    end
    hcnt_n = hrem + {1'b0, in_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i] <= 16'h0;
      hcnt      <= 3'd0;
      rsp_valid <= 1'b0;
      fetch_pc  <= RESET_PC & ~32'h3 & PC_MASK;
      head_pc   <= RESET_PC & ~32'h1 & PC_MASK;
      drop_lo   <= RESET_PC[1];
    end else if (redirect_valid) begin
      // The word in flight belongs to the old path and is discarded.
      hcnt      <= 3'd0;
      rsp_valid <= 1'b0;
      fetch_pc  <= redirect_pc & ~32'h3 & PC_MASK;
      head_pc   <= redirect_pc & ~32'h1 & PC_MASK;
      drop_lo   <= redirect_pc[1];
    end else begin
      for (int i = 0; i < 4; i++) q[i] <= q_n[i];
      hcnt      <= hcnt_n;
      rsp_valid <= issue;
      if (issue)
        fetch_pc <= ((fetch_pc & ~32'h3) + 32'd4) & PC_MASK;
      if (consume)
        head_pc <= (head_pc + (q0_is_c ? 32'd2 : 32'd4)) & PC_MASK;
      if (rsp_valid)
        drop_lo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: synchronous imem model, per-scenario tasks, expected instructions queued ahead of the DUT.
module tb_fetch_align;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_is_c;

  logic [31:0] mem [2**AW];
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_pc [$];
  logic [31:0] exp_ins [$];
  logic        exp_c [$];

  fetch_align #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_is_c(instr_is_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0;
    exp_pc.delete(); exp_ins.delete(); exp_c.delete();
  endtask

  task automatic end_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic c);
    exp_pc.push_back(pc); exp_ins.push_back(ins); exp_c.push_back(c);
  endtask

  task automatic test_reset();
    begin_reset();
    @(negedge clk);
    tests_run++;
    if ({instr_valid, instr_is_c} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_valid: got valid/is_c %b want 00", {instr_valid, instr_is_c});
    end
    tests_run++;
    if (instr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_instr: got %h want 00000000", instr);
    end
    tests_run++;
    if ({instr_pc, 21'(imem_addr)} !== 53'h0) begin
      tests_failed++; $display("FAIL reset_pc: got pc %h addr %h want 0/0", instr_pc, imem_addr);
    end
  endtask

  task automatic test_four_word();
    logic [31:0] pc, ins; logic c;
    begin_reset();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'h00100093 + (32'(i) << 20);
      push(32'(4 * i), mem[i], 1'b0);
    end
    end_reset();
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL four_word_early: got valid %b want 0", instr_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pc = exp_pc.pop_front(); ins = exp_ins.pop_front(); c = exp_c.pop_front();
      tests_run++;
      if ({instr_valid, instr_pc, instr, instr_is_c} !== {1'b1, pc, ins, c}) begin
        tests_failed++;
        $display("FAIL four_word_%0d: got v%b pc %h ins %h c%b want v1 pc %h ins %h c%b",
                 k, instr_valid, instr_pc, instr, instr_is_c, pc, ins, c);
      end
    end
  endtask

  task automatic test_straddle();
    logic [31:0] pc, ins; logic c;
    begin_reset();
    mem[0] = {16'h0293, 16'h0085};
    mem[1] = {16'h0001, 16'h0050};
    push(32'h0, 32'h00000085, 1'b1);
    push(32'h2, 32'h00500293, 1'b0);
    push(32'h6, 32'h00000001, 1'b1);
    end_reset();
    for (int cyc = 0; cyc < 20 && exp_pc.size() > 0; cyc++) begin
      @(negedge clk);
      if (instr_valid) begin
        pc = exp_pc.pop_front(); ins = exp_ins.pop_front(); c = exp_c.pop_front();
        tests_run++;
        if ({instr_pc, instr, instr_is_c} !== {pc, ins, c}) begin
          tests_failed++;
          $display("FAIL straddle: got pc %h ins %h c%b want pc %h ins %h c%b",
                   instr_pc, instr, instr_is_c, pc, ins, c);
        end
      end
    end
    tests_run++;
    if (exp_pc.size() != 0) begin
      tests_failed++; $display("FAIL straddle_timeout: got %0d pending want 0", exp_pc.size());
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pc, ins; logic c;
    begin_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'h00100093 + (32'(i) << 20);
    mem[32'h40] = {16'h0045, 16'hdead};
    mem[32'h41] = 32'h00700393;
    push(32'h102, 32'h00000045, 1'b1);
    push(32'h104, 32'h00700393, 1'b0);
    end_reset();
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++; $display("FAIL redirect_gap_%0d: got valid %b want 0", k, instr_valid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pc = exp_pc.pop_front(); ins = exp_ins.pop_front(); c = exp_c.pop_front();
      tests_run++;
      if ({instr_valid, instr_pc, instr, instr_is_c} !== {1'b1, pc, ins, c}) begin
        tests_failed++;
        $display("FAIL redirect_%0d: got v%b pc %h ins %h c%b want v1 pc %h ins %h c%b",
                 k, instr_valid, instr_pc, instr, instr_is_c, pc, ins, c);
      end
    end
  endtask

  task automatic test_rvc_stall();
    logic [31:0] pc, ins, want_addr; logic c;
    logic [15:0] h;
    begin_reset();
    for (int k = 0; k < 16; k++) begin
      h = 16'h4001 | (16'(k) << 2);
      if (k % 2 == 0) mem[k/2][15:0] = h; else mem[k/2][31:16] = h;
      push(32'(2 * k), {16'h0, h}, 1'b1);
    end
    end_reset();
    for (int cyc = 0; cyc < 60 && exp_pc.size() > 0; cyc++) begin
      @(negedge clk);
      stall = (cyc >= 6 && cyc < 11);
      if (stall && cyc > 6) begin
        tests_run++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[0], exp_ins[0]}) begin
          tests_failed++;
          $display("FAIL stall_hold_%0d: got v%b pc %h ins %h want v1 pc %h ins %h",
                   cyc, instr_valid, instr_pc, instr, exp_pc[0], exp_ins[0]);
        end
      end
      if (stall && cyc >= 9) begin
        want_addr = ((exp_pc[0] >> 1) + 32'd4) >> 1;
        tests_run++;
        if (32'(imem_addr) !== want_addr) begin
          tests_failed++; $display("FAIL stall_addr_%0d: got %h want %h", cyc, imem_addr, want_addr);
        end
      end
      if (instr_valid && !stall) begin
        pc = exp_pc.pop_front(); ins = exp_ins.pop_front(); c = exp_c.pop_front();
        tests_run++;
        if ({instr_pc, instr, instr_is_c} !== {pc, ins, c}) begin
          tests_failed++;
          $display("FAIL rvc_stream: got pc %h ins %h c%b want pc %h ins %h c%b",
                   instr_pc, instr, instr_is_c, pc, ins, c);
        end
      end
    end
    stall = 1'b0;
    tests_run++;
    if (exp_pc.size() != 0) begin
      tests_failed++; $display("FAIL rvc_timeout: got %0d pending want 0", exp_pc.size());
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] pc, ins; logic c;
    begin_reset();
    mem[0] = 32'h00100093;
    mem[32'h80] = 32'h00900493;
    mem[32'h81] = 32'h00a00513;
    push(32'h200, 32'h00900493, 1'b0);
    push(32'h204, 32'h00a00513, 1'b0);
    end_reset();
    @(negedge clk);
    redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      redirect_valid = 1'b0; stall = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++; $display("FAIL redir_stall_gap_%0d: got valid %b want 0", k, instr_valid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pc = exp_pc.pop_front(); ins = exp_ins.pop_front(); c = exp_c.pop_front();
      tests_run++;
      if ({instr_valid, instr_pc, instr, instr_is_c} !== {1'b1, pc, ins, c}) begin
        tests_failed++;
        $display("FAIL redir_stall_%0d: got v%b pc %h ins %h c%b want v1 pc %h ins %h c%b",
                 k, instr_valid, instr_pc, instr, instr_is_c, pc, ins, c);
      end
    end
  endtask

  task automatic test_async_reset();
    begin_reset();
    for (int i = 0; i < 8; i++) mem[i] = 32'h00100093 + (32'(i) << 20);
    end_reset();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h0}) begin
      tests_failed++; $display("FAIL async_reset: got v%b pc %h want v0 pc 0", instr_valid, instr_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL restart_early: got valid %b want 0", instr_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h00100093}) begin
      tests_failed++;
      $display("FAIL restart_first: got v%b pc %h ins %h want v1 pc 0 ins 00100093", instr_valid, instr_pc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_four_word();
    test_straddle();
    test_redirect();
    test_rvc_stall();
    test_redirect_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end

endmodule
